// File: rtl/chan_mux_stream.sv
// N-channel, W-bit flow-controlled stream mux with a registered output stage.
// Define CHAN_MUX_STREAM_RR_EN to compile in the round-robin scan and its pointer.
module chan_mux_stream #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [NCH-1:0][WIDTH-1:0] in_vec;
  logic                      load, xfer;
  logic                      gnt_vld;
  logic [SELW-1:0]           gnt_idx;

  logic [WIDTH-1:0]          data_q, data_d;
  logic [SELW-1:0]           ch_q, ch_d;
  logic                      vld_q, vld_d;

  assign in_vec = in_data;
  assign load   = !vld_q || out_ready;
  assign xfer   = gnt_vld && load;

`ifdef CHAN_MUX_STREAM_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  int              cand;
`else
  logic            unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef CHAN_MUX_STREAM_RR_EN
    cand    = 0;
    if (mode) begin
      // first valid channel strictly after the last round-robin winner
      for (int k = 1; k <= NCH; k++) begin
        cand = int'(ptr_q) + k;
        if (cand >= NCH) cand = cand - NCH;
        if (!gnt_vld && in_valid[SELW'(cand)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(cand);
        end
      end
    end else
`endif
    if (int'(sel) < NCH && in_valid[sel]) begin
      gnt_vld = 1'b1;
      gnt_idx = sel;
    end
  end

  // in_ready is gated by rst_n so it drops the instant reset asserts
  for (genvar i = 0; i < NCH; i++) begin : g_rdy
    assign in_ready[i] = rst_n && xfer && (gnt_idx == SELW'(i));
  end

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    if (load) begin
      vld_d = xfer;
      if (xfer) begin
        data_d = in_vec[gnt_idx];
        ch_d   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
    end
  end

`ifdef CHAN_MUX_STREAM_RR_EN
  assign ptr_d = (xfer && mode) ? gnt_idx : ptr_q;

  // reset to NCH-1 so the first round-robin grant lands on channel 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SELW'(NCH-1);
    else        ptr_q <= ptr_d;
  end
`endif

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_chan_mux_stream.sv
// Directed bench for chan_mux_stream: a 4-channel and a 3-channel instance.
module tb_chan_mux_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // NCH=4 instance
  logic        mode, out_ready, out_valid;
  logic [1:0]  sel, out_ch;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;

  // NCH=3 instance
  logic        mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_ch3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;

  int total = 0;
  int bad   = 0;

  chan_mux_stream #(.WIDTH(8), .NCH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  chan_mux_stream #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
  int rr_13  [4] = '{3, 1, 3, 1};
  int rr_3   [4] = '{0, 1, 2, 0};

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    in_data = 32'h4433_2211; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = 24'hCC_BBAA; out_ready3 = 1'b1;

    // reset state, with valid inputs present
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ch", out_ch, 0);
    chk("rst_rdy", in_ready, 4'b0000);
    chk("rst_rdy3", in_ready3, 3'b000);

    // manual select
    #10 rst_n = 1'b1;
    sel = 2'd2;
    #1 chk("man_rdy", in_ready, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("man_data", out_data, 8'h33);
      chk("man_ch", out_ch, 2);
      chk("man_vld", out_valid, 1);
      chk("man_rdy2", in_ready, 4'b0100);
    end

    // round-robin, all valid
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef CHAN_MUX_STREAM_RR_EN
      chk("rr_ch", out_ch, rr_seq[i]);
      chk("rr_data", out_data, 8'h11 * (rr_seq[i] + 1));
`else
      chk("rr_ch", out_ch, 2);
      chk("rr_data", out_data, 8'h33);
`endif
    end

    // only channels 1 and 3 valid; last winner was 1
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef CHAN_MUX_STREAM_RR_EN
      chk("rr13_ch", out_ch, rr_13[i]);
      chk("rr13_vld", out_valid, 1);
`else
      chk("rr13_vld", out_valid, 0);
      chk("rr13_ch", out_ch, 2);
`endif
    end

    // idle: output drains, channel held
    in_valid = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_vld", out_valid, 0);
`ifdef CHAN_MUX_STREAM_RR_EN
      chk("idle_ch", out_ch, 1);
`else
      chk("idle_ch", out_ch, 2);
`endif
    end

    // pointer untouched by idle cycles: next grant after 1 is 2
    in_valid = 4'hF;
    tick();
    chk("ptr_ch", out_ch, 2);
    chk("ptr_vld", out_valid, 1);

    // manual sel at an invalid channel
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1110;
    #1 chk("inv_rdy", in_ready, 4'b0000);
    tick();
    chk("inv_vld", out_valid, 0);

    // backpressure
    in_valid = 4'b0001; in_data = 32'h4433_22A5;
    tick();
    chk("bp_load", out_data, 8'hA5);
    out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h4433_5AA5;
    #1 chk("bp_rdy0", in_ready, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", out_data, 8'hA5);
      chk("bp_vld", out_valid, 1);
      chk("bp_rdy", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", in_ready, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_rel_data", out_data, 8'h5A);
      chk("bp_rel_ch", out_ch, 1);
      chk("bp_rel_vld", out_valid, 1);
    end

    // asynchronous reset mid-stream, inputs still valid
    in_valid = 4'hF; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_data", out_data, 8'h00);
    chk("mrst_ch", out_ch, 0);
    chk("mrst_rdy", in_ready, 4'b0000);
    #3 rst_n = 1'b1;
    mode = 1'b1; out_ready = 1'b1; sel = 2'd1;
    tick();
`ifdef CHAN_MUX_STREAM_RR_EN
    chk("post_rst_ch", out_ch, 0);
    chk("post_rst_data", out_data, 8'hA5);
`else
    chk("post_rst_ch", out_ch, 1);
    chk("post_rst_data", out_data, 8'h5A);
`endif

    // NCH=3: out-of-range sel, then round-robin wrap
    sel3 = 2'd3; mode3 = 1'b0; in_valid3 = 3'b111;
    #1 chk("n3_rdy", in_ready3, 3'b000);
    tick();
    chk("n3_vld", out_valid3, 0);
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef CHAN_MUX_STREAM_RR_EN
      chk("n3_rr_ch", out_ch3, rr_3[i]);
      chk("n3_rr_data", out_data3, 8'hAA + 8'h11 * rr_3[i]);
`else
      chk("n3_rr_vld", out_valid3, 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_mux_stream.md
# chan_mux_stream

Parametrised N-channel, W-bit streaming multiplexer with a registered output and valid/ready handshakes on every input and on the output. It generalises the team's fixed 4:1 8-bit combinational select into a flow-controlled stage. Channel choice is either software-selected (manual) or a fair round-robin scan. It sits between multiple data sources and a single downstream consumer, such as a display or bus register.

## Interface
- `WIDTH`, default 8: data width per channel, ≥1.
- `NCH`, default 4: number of input channels, ≥2; need not be a power of two.
- `SELW` (localparam): `$clog2(NCH)`, the width of channel indices.

- `clk`  input  1  the single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `mode`  input  1  channel-choice mode: 0 = manual (uses `sel`), 1 = round-robin.
- `sel`  input  SELW  manual channel index; ignored when `mode`=1.
- `in_data`  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  input  NCH  per-channel valid.
- `in_ready`  output  NCH  per-channel ready; one-hot or zero.
- `out_data`  output  WIDTH  registered output data.
- `out_ch`  output  SELW  index of the channel that supplied `out_data`.
- `out_valid`  output  1  output holds a word.
- `out_ready`  input  1  consumer accepts the word.

## Operation
- A single output register holds `out_data`, `out_ch` and `out_valid`.
- Load enable: `load = !out_valid | out_ready`.
- Grant is computed combinationally each cycle:
  - Manual mode: grant = `sel` if `sel` < NCH and `in_valid[sel]`; otherwise no grant.
  - Round-robin mode: grant = the first channel with `in_valid` set, scanning upward from `ptr+1` modulo NCH and wrapping. If no input is valid, there is no grant.
- `in_ready[g] = load` for granted channel g. All other bits of `in_ready` are 0.
- An input transfer occurs when `in_valid[g] & in_ready[g]`. On the next edge the register loads `in_data[g]`, `out_ch` = g, and `out_valid` = 1. In round-robin mode, `ptr` is also set to g.
- When `load` is asserted but there is no grant, `out_valid` becomes 0 and `out_data`/`out_ch` hold their previous values.
- When `out_valid & !out_ready`, the output register and `ptr` hold and all `in_ready` bits are 0.
- `ptr` updates only on round-robin transfers. Manual transfers leave it unchanged.
- Changes to `mode` or `sel` affect only the grant in the same cycle. A word already in the output register is never altered.
- Out-of-range `sel` (possible when NCH is not a power of two) results in no grant and no error flag.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=NCH-1. With these values, the first round-robin grant goes to channel 0.
- Reset is asynchronous. Assertion mid-transfer discards the held word immediately and forces `in_ready` to 0 the same instant.
- Latency: input transfer at edge k gives `out_valid`=1 with that data after edge k.
- Throughput: one word per cycle when `out_ready` is held high.
- Back-to-back transfers are allowed. In the same cycle that the consumer accepts a word, a new word is loaded.
- `in_ready` may depend on `in_valid` and `out_ready`. `out_valid` never depends on `out_ready` combinationally.
- Round-robin fairness: with all channels valid continuously, grants cycle 0,1,…,NCH-1,0,… with no repeats before a full wrap.

## Configuration
- Macro: `CHAN_MUX_STREAM_RR_EN`.
  - Defined: round-robin logic and `ptr` are compiled in; `mode` behaves as described above.
  - Undefined: `ptr` and the scan logic are omitted. The `mode` port remains but is ignored, and the block always operates in manual mode. Port list and reset values are otherwise unchanged.

## Test plan
Default parameters (WIDTH=8, NCH=4) unless stated.

- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`=0, `out_data`=0x00, `out_ch`=0, `in_ready`=0000 immediately. After release, the first round-robin grant is channel 0.
- **Manual select:**
  - Input: `mode`=0, `sel`=2, `in_data`={D=0x44,C=0x33,B=0x22,A=0x11}, all valid, `out_ready`=1.
  - Expected: `in_ready`=0100; one cycle later `out_data`=0x33, `out_ch`=2 every cycle.
- **Round-robin:**
  - Input: `mode`=1, all four valid, `out_ready`=1.
  - Expected: `out_ch` sequence 0,1,2,3,0,1. With only channels 1 and 3 valid, the sequence is 1,3,1,3.
- **Backpressure:**
  - Input: word 0xA5 held in the output, `out_ready`=0 for 5 cycles.
  - Expected: `out_data`=0xA5 is stable and `in_ready`=0000 throughout. Raising `out_ready` with channel 1 valid (0x5A) produces 0x5A on the next cycle with no bubble.
- **Empty/idle:**
  - Input: no `in_valid` bits set, `out_ready`=1.
  - Expected: `out_valid` drops to 0 after the current word drains, and `ptr` is unchanged. Manual `sel` pointing at an invalid channel produces no transfer.
- **Non-power-of-two:**
  - Input: NCH=3, `sel`=3.
  - Expected: no grant, `in_ready`=000. In round-robin mode, grants wrap 2→0.
